mips_cpu_muldiv: RTL and testbench

Iterative multiply/divide unit with architectural HI/LO registers. It implements MULT, MULTU, DIV, DIVU, MTHI and MTLO, generalised to a parametrised data width. It sits beside the combinational ALU in the execute stage. The control unit issues an op with a one-cycle start pulse, stalls on busy, and reads HI/LO, for MFHI/MFLO, from the registered outputs.

---
 rtl/mips_cpu_muldiv_pkg.sv | 23 ++
 rtl/mips_cpu_muldiv_datapath.sv | 35 +++
 rtl/mips_cpu_muldiv.sv | 165 ++++++++++++++++
 tb/tb_mips_cpu_muldiv.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/mips_cpu_muldiv_pkg.sv
// Shared types for the iterative multiply/divide unit: op encoding and FSM states.
package mips_cpu_muldiv_pkg;

    typedef enum logic [2:0] {
        MD_NOP   = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6,
        MD_RSVD  = 3'd7
    } muldiv_op_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL  = 3'd1,
        ST_DIV  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } muldiv_state_t;

endpackage

// File: rtl/mips_cpu_muldiv_datapath.sv
// One iteration of radix-2 shift-add multiply or restoring divide on unsigned magnitudes.
module mips_cpu_muldiv_datapath #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 div_mode,
    input  logic [2*WIDTH-1:0]   acc_i,
    input  logic [WIDTH-1:0]     opa_i,
    input  logic [WIDTH-1:0]     opb_i,
    output logic [2*WIDTH-1:0]   acc_o,
    output logic [WIDTH-1:0]     opa_o,
    output logic [WIDTH-1:0]     opb_o
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] diff;

    always_comb begin
        sum    = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (opb_i[0] ? {1'b0, opa_i} : {(WIDTH+1){1'b0}});
        // Remainder stays below the divisor, so the shifted value fits in WIDTH+1 bits.
        rem_sh = {acc_i[2*WIDTH-1:WIDTH], opa_i[WIDTH-1]};
        diff   = rem_sh - {1'b0, opb_i};
        if (div_mode) begin
            acc_o = {(diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0]),
                     acc_i[WIDTH-2:0], ~diff[WIDTH]};
            opa_o = {opa_i[WIDTH-2:0], 1'b0};
            opb_o = opb_i;
        end else begin
            acc_o = {sum, acc_i[WIDTH-1:1]};
            opa_o = opa_i;
            opb_o = {1'b0, opb_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mips_cpu_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO and MTHI/MTLO writes.
module mips_cpu_muldiv
    import mips_cpu_muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    muldiv_state_t        state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     opa_q, opa_d, opb_q, opb_d;
    logic                 sign_a_q, sign_a_d, sign_b_q, sign_b_d;
    logic                 is_div_q, is_div_d, divz_q, divz_d;
    logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
    logic                 busy_q, busy_d, done_q, done_d;

    logic [2*WIDTH-1:0]   acc_step;
    logic [WIDTH-1:0]     opa_step, opb_step;
    logic [WIDTH-1:0]     quot_fix, rem_fix;

    mips_cpu_muldiv_datapath #(.WIDTH(WIDTH)) u_datapath (
        .div_mode (is_div_q),
        .acc_i    (acc_q),
        .opa_i    (opa_q),
        .opb_i    (opb_q),
        .acc_o    (acc_step),
        .opa_o    (opa_step),
        .opb_o    (opb_step)
    );

    // Next-state and datapath control
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        is_div_d = is_div_q;
        divz_d   = divz_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        quot_fix = acc_q[WIDTH-1:0];
        rem_fix  = acc_q[2*WIDTH-1:WIDTH];

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    acc_d    = '0;
                    cnt_d    = '0;
                    divz_d   = (b == '0);
                    sign_a_d = 1'b0;
                    sign_b_d = 1'b0;
                    opa_d    = a;
                    opb_d    = b;
                    case (muldiv_op_t'(op))
                        MD_MTHI: hi_d = a;
                        MD_MTLO: lo_d = a;
                        MD_MULT, MD_DIV: begin
                            sign_a_d = a[WIDTH-1];
                            sign_b_d = b[WIDTH-1];
                            opa_d    = a[WIDTH-1] ? -a : a;
                            opb_d    = b[WIDTH-1] ? -b : b;
                        end
                        default: ;
                    endcase
                    case (muldiv_op_t'(op))
                        MD_MULT, MD_MULTU: begin
                            is_div_d = 1'b0;
                            state_d  = ST_MUL;
                        end
                        MD_DIV, MD_DIVU: begin
                            is_div_d = 1'b1;
                            state_d  = ST_DIV;
                        end
                        default: ;
                    endcase
                end
            end
            ST_MUL, ST_DIV: begin
                acc_d = acc_step;
                opa_d = opa_step;
                opb_d = opb_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                // Truncating division: remainder follows the dividend's sign.
                if (is_div_q) begin
                    rem_fix  = sign_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
                    quot_fix = divz_q ? '1
                             : ((sign_a_q ^ sign_b_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
                    acc_d    = {rem_fix, quot_fix};
                end else begin
                    acc_d = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
                end
                state_d = ST_DONE;
            end
            ST_DONE: begin
                hi_d    = acc_q[2*WIDTH-1:WIDTH];
                lo_d    = acc_q[WIDTH-1:0];
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            is_div_q <= 1'b0;
            divz_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            is_div_q <= is_div_d;
            divz_q   <= divz_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_mips_cpu_muldiv.sv
// Directed bench for mips_cpu_muldiv (WIDTH=32): vector table plus busy/back-to-back/reset sequences.
module tb_mips_cpu_muldiv;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;
    localparam int         LAT      = 34;
    localparam int         NVEC     = 12;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;
    int lat;
    vec_t vecs [NVEC];

    mips_cpu_muldiv #(.WIDTH(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .hi      (hi),
        .lo      (lo),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts edges since accept until done is seen, bounded.
    task automatic wait_done(input int from, output int n);
        n = from;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        vecs[0]  = '{OP_MULT,  32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE};
        vecs[1]  = '{OP_MULTU, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE};
        vecs[2]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{OP_DIVU,  32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003};
        vecs[4]  = '{OP_DIVU,  32'h00000055, 32'h00000000, 32'h00000055, 32'hFFFFFFFF};
        vecs[5]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[6]  = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[7]  = '{OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[8]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF};
        vecs[9]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[10] = '{OP_DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF};
        vecs[11] = '{OP_MULT,  32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB};

        reset_n = 1'b0;
        start   = 1'b0;
        op      = 3'd0;
        a       = '0;
        b       = '0;
        repeat (2) @(negedge clk);
        chk("reset_hi",   64'(hi),   64'h0);
        chk("reset_lo",   64'(lo),   64'h0);
        chk("reset_busy", 64'(busy), 64'h0);
        chk("reset_done", 64'(done), 64'h0);
        reset_n = 1'b1;
        @(negedge clk);

        issue(OP_MTHI, 32'h12345678, 32'h0);
        chk("mthi_hi",   64'(hi),   64'h12345678);
        chk("mthi_busy", 64'(busy), 64'h0);
        chk("mthi_done", 64'(done), 64'h0);
        issue(OP_MTLO, 32'h9ABCDEF0, 32'h0);
        chk("mtlo_lo",   64'(lo),   64'h9ABCDEF0);
        chk("mtlo_hi",   64'(hi),   64'h12345678);
        chk("mtlo_busy", 64'(busy), 64'h0);

        for (int i = 0; i < NVEC; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            chk($sformatf("v%0d_busy", i), 64'(busy), 64'h1);
            wait_done(0, lat);
            chk($sformatf("v%0d_lat", i),   64'(lat),  64'(LAT));
            chk($sformatf("v%0d_hi", i),    64'(hi),   64'(vecs[i].hi));
            chk($sformatf("v%0d_lo", i),    64'(lo),   64'(vecs[i].lo));
            chk($sformatf("v%0d_idle", i),  64'(busy), 64'h0);
        end
        @(negedge clk);
        chk("done_one_cycle", 64'(done), 64'h0);

        // Start while busy is ignored; back-to-back start in the done cycle is taken
        issue(OP_MULTU, 32'd3, 32'd5);
        @(negedge clk);
        start = 1'b1;
        op    = OP_DIVU;
        a     = 32'd100;
        b     = 32'd7;
        @(negedge clk);
        start = 1'b0;
        wait_done(2, lat);
        chk("ign_lat", 64'(lat), 64'(LAT));
        chk("ign_hi",  64'(hi),  64'h0);
        chk("ign_lo",  64'(lo),  64'd15);
        issue(OP_DIVU, 32'd7, 32'd2);
        chk("b2b_busy", 64'(busy), 64'h1);
        wait_done(0, lat);
        chk("b2b_lat", 64'(lat), 64'(LAT));
        chk("b2b_hi",  64'(hi),  64'h1);
        chk("b2b_lo",  64'(lo),  64'h3);

        // Asynchronous reset mid-operation
        issue(OP_MULT, 32'hFFFFFFFF, 32'h00000002);
        repeat (9) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_done", 64'(done), 64'h0);
        chk("rst_hi",   64'(hi),   64'h0);
        chk("rst_lo",   64'(lo),   64'h0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_stays_idle", 64'(busy), 64'h0);
        issue(OP_MULTU, 32'h00010000, 32'h00010000);
        wait_done(0, lat);
        chk("post_rst_lat", 64'(lat), 64'(LAT));
        chk("post_rst_hi",  64'(hi),  64'h1);
        chk("post_rst_lo",  64'(lo),  64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
